// File: rtl/axi_lite_ram.sv
// AXI4-Lite responder word memory with byte strobes and SLVERR on out-of-range accesses.
// Independent read and write channels, one outstanding transaction each.
module axi_lite_ram #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] axi_awaddr,
   input  logic [2:0]  axi_awprot,
   input  logic        axi_awvalid,
   output logic        axi_awready,
   input  logic [31:0] axi_wdata,
   input  logic [3:0]  axi_wstrb,
   input  logic        axi_wvalid,
   output logic        axi_wready,
   output logic [1:0]  axi_bresp,
   output logic        axi_bvalid,
   input  logic        axi_bready,
   input  logic [31:0] axi_araddr,
   input  logic [2:0]  axi_arprot,
   input  logic        axi_arvalid,
   output logic        axi_arready,
   output logic [31:0] axi_rdata,
   output logic [1:0]  axi_rresp,
   output logic        axi_rvalid,
   input  logic        axi_rready
);

   localparam int unsigned IDX_W     = $clog2(DEPTH);
   localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
   localparam logic [1:0]  RESP_OKAY = 2'b00;
   localparam logic [1:0]  RESP_SLV  = 2'b10;

   typedef enum logic {WIdle, WResp} w_state_e;
   typedef enum logic {RIdle, RResp} r_state_e;

   logic [31:0] mem [DEPTH];

   w_state_e    w_state_q, w_state_d;
   logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  bresp_q, bresp_d;

   r_state_e    r_state_q, r_state_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   logic        aw_hs, w_hs, commit, mem_we, wr_in_range, rd_in_range;
   logic [31:0] wr_addr, wr_data, wr_off, rd_off;
   logic [3:0]  wr_strb;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   logic unused_prot;
   assign unused_prot = ^{axi_awprot, axi_arprot};

   // Readies depend only on registered state.
   assign axi_awready = (w_state_q == WIdle) && !aw_held_q;
   assign axi_wready  = (w_state_q == WIdle) && !w_held_q;
   assign axi_bvalid  = (w_state_q == WResp);
   assign axi_bresp   = bresp_q;
   assign axi_arready = (r_state_q == RIdle);
   assign axi_rvalid  = (r_state_q == RResp);
   assign axi_rdata   = rdata_q;
   assign axi_rresp   = rresp_q;

   assign aw_hs = axi_awvalid && axi_awready;
   assign w_hs  = axi_wvalid && axi_wready;

   // Held values take priority; otherwise the beat handshaking this cycle is used.
   assign wr_addr = aw_held_q ? awaddr_q : axi_awaddr;
   assign wr_data = w_held_q ? wdata_q : axi_wdata;
   assign wr_strb = w_held_q ? wstrb_q : axi_wstrb;

   assign wr_off      = wr_addr - BASE_ADDR;
   assign wr_in_range = wr_off < MEM_BYTES;
   assign wr_idx      = wr_off[IDX_W+1:2];
   assign rd_off      = axi_araddr - BASE_ADDR;
   assign rd_in_range = rd_off < MEM_BYTES;
   assign rd_idx      = rd_off[IDX_W+1:2];

   assign commit = (w_state_q == WIdle) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign mem_we = commit && wr_in_range && !reset;

   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         WIdle: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awaddr_d  = axi_awaddr;
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = axi_wdata;
               wstrb_d  = axi_wstrb;
            end
            if (commit) begin
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLV;
               w_state_d = WResp;
            end
         end
         WResp:   if (axi_bready) w_state_d = WIdle;
         default: w_state_d = WIdle;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         RIdle: begin
            if (axi_arvalid) begin
               r_state_d = RResp;
               rdata_d   = rd_in_range ? mem[rd_idx] : 32'h0;
               rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLV;
            end
         end
         RResp:   if (axi_rready) r_state_d = RIdle;
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state_q <= WIdle;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         bresp_q   <= RESP_OKAY;
         r_state_q <= RIdle;
         rdata_q   <= 32'h0;
         rresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Contents survive reset; a same-edge read sees the old word.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed self-checking bench for axi_lite_ram (DEPTH=16, non-zero base address).
module tb_axi_lite_ram;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk, reset;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;

   int n_checks = 0;
   int n_pass   = 0;

   axi_lite_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset),
      .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
      .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
      .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
      .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(arready),
      .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
      awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check({tag, "_bvalid"}, {31'h0, bvalid}, 32'h1);
      check({tag, "_bresp"}, {30'h0, bresp}, {30'h0, exp_resp});
      tick();
      check({tag, "_bdone"}, {29'h0, awready, wready, bvalid}, 32'h6);
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      tick();
      arvalid = 1'b0;
      check({tag, "_rvalid"}, {31'h0, rvalid}, 32'h1);
      check({tag, "_rdata"}, rdata, exp_data);
      check({tag, "_rresp"}, {30'h0, rresp}, {30'h0, exp_resp});
      tick();
      check({tag, "_rdone"}, {30'h0, arready, rvalid}, 32'h2);
   endtask

   initial begin
      reset = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      #2;
      check("rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
      check("rst_resps", {28'h0, bresp, rresp}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      tick(); tick();
      reset = 1'b0;
      check("rst_readies", {29'h0, awready, wready, arready}, 32'h7);

      axi_write(BASE + 32'h00, 32'h0BAD_F00D, 4'hF, 2'b00, "wr_w0");
      axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, "wr_full");
      axi_read(BASE + 32'h10, 32'hDEAD_BEEF, 2'b00, "rd_full");

      // Split write: W first, AW three cycles later.
      wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
      tick();
      wvalid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         check("split_wready", {31'h0, wready}, 32'h0);
         check("split_awready", {31'h0, awready}, 32'h1);
         check("split_bvalid", {31'h0, bvalid}, 32'h0);
         if (i < 3) tick();
      end
      awaddr = BASE + 32'h10; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("split_bvalid_rise", {31'h0, bvalid}, 32'h1);
      check("split_bresp", {30'h0, bresp}, 32'h0);
      tick();
      axi_read(BASE + 32'h10, 32'hDE22_BE44, 2'b00, "rd_split");

      // Out of range, boundaries and zero strobe.
      axi_write(BASE + 32'h40, 32'h1234_5678, 4'hF, 2'b10, "wr_oor");
      axi_read(BASE + 32'h40, 32'h0, 2'b10, "rd_oor");
      axi_read(BASE + 32'h00, 32'h0BAD_F00D, 2'b00, "rd_w0_intact");
      axi_read(BASE - 32'h4, 32'h0, 2'b10, "rd_below_base");
      axi_write(BASE + 32'h3C, 32'h600D_CAFE, 4'hF, 2'b00, "wr_last");
      axi_read(BASE + 32'h3C, 32'h600D_CAFE, 2'b00, "rd_last");
      axi_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, 2'b00, "wr_nostrb");
      axi_read(BASE + 32'h10, 32'hDE22_BE44, 2'b00, "rd_nostrb");

      // Backpressure on both response channels.
      awaddr = BASE + 32'h08; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = BASE + 32'h10; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_valids", {30'h0, bvalid, rvalid}, 32'h3);
         check("bp_rdata", rdata, 32'hDE22_BE44);
         check("bp_resps", {28'h0, bresp, rresp}, 32'h0);
         check("bp_readies", {29'h0, awready, wready, arready}, 32'h0);
         tick();
      end
      bready = 1'b1; rready = 1'b1;
      tick();
      check("bp_release_valids", {30'h0, bvalid, rvalid}, 32'h0);
      check("bp_release_readies", {29'h0, awready, wready, arready}, 32'h7);
      axi_read(BASE + 32'h08, 32'hCAFE_F00D, 2'b00, "rd_bp_write");

      // Read-before-write collision.
      axi_write(BASE + 32'h20, 32'hAAAA_AAAA, 4'hF, 2'b00, "wr_coll_init");
      awaddr = BASE + 32'h20; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = BASE + 32'h20; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("coll_valids", {30'h0, bvalid, rvalid}, 32'h3);
      check("coll_old_data", rdata, 32'hAAAA_AAAA);
      tick();
      axi_read(BASE + 32'h20, 32'h5555_5555, 2'b00, "rd_coll_new");

      // Asynchronous reset with both responses pending.
      axi_write(BASE + 32'h24, 32'h1111_1111, 4'hF, 2'b00, "wr_pre_rst");
      awaddr = BASE + 32'h04; wdata = 32'h7777_7777; awvalid = 1'b1; wvalid = 1'b1;
      araddr = BASE + 32'h24; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("pre_rst_valids", {30'h0, bvalid, rvalid}, 32'h3);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
      check("async_rst_rdata", rdata, 32'h0);
      // A write offered only while reset is held must not land.
      awaddr = BASE + 32'h24; wdata = 32'h9999_9999; awvalid = 1'b1; wvalid = 1'b1;
      tick(); tick();
      awvalid = 1'b0; wvalid = 1'b0;
      reset = 1'b0;
      check("post_rst_readies", {29'h0, awready, wready, arready}, 32'h7);
      check("post_rst_bvalid", {31'h0, bvalid}, 32'h0);
      axi_read(BASE + 32'h24, 32'h1111_1111, 2'b00, "rd_rst_nowrite");
      axi_read(BASE + 32'h04, 32'h7777_7777, 2'b00, "rd_pre_rst_commit");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
